dbg_dump_sequencer: RTL

Debug-unit controller that streams a snapshot of pipeline state to the host over the UART TX FIFO. On a start pulse from the debugger command decoder it serializes a framed dump: PC, all general registers, and a host-selected number of data-memory words, one byte at a time. It sits between the pipeline's debug read ports (register file, data memory, PC) and the `uart_top` TX write interface, sequencing reads and throttling on `tx_full`.

---
 rtl/dbg_pkg.sv | 8 +
 rtl/dbg_word_serializer.sv | 48 ++++
 rtl/dbg_dump_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared encodings and constants for the debug dump sequencer.
package dbg_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ADDR, S_LATCH, S_SEND, S_TRL, S_DONE} state_t;
  typedef enum logic [1:0] {SEC_PC, SEC_REG, SEC_MEM} sec_t;
  localparam logic [7:0] DBG_HDR = 8'hA5;
  localparam logic [7:0] DBG_TRL = 8'h5A;
  localparam int NB_BIDX = 2;
endpackage

// File: rtl/dbg_word_serializer.sv
// dbg_word_serializer: MSB-first byte emitter for a loaded word, plus single framing bytes.
// A byte fires only when the FIFO is not full and no strobe was issued last cycle.
module dbg_word_serializer
  import dbg_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_send,
  input  logic               i_byte_req,
  input  logic [NB_BYTE-1:0] i_byte,
  input  logic               i_tx_full,
  output logic [NB_BYTE-1:0] o_w_data,
  output logic               o_wr,
  output logic               o_fire,
  output logic               o_last
);
  logic [NB_DATA-1:0] word_q;
  logic [NB_BIDX-1:0] bidx_q;
  logic [NB_BYTE-1:0] data_q;
  logic               wr_q;
  assign o_fire   = (i_send | i_byte_req) & ~i_tx_full & ~wr_q;
  assign o_last   = o_fire & i_send & (bidx_q == NB_BIDX'(NB_DATA / NB_BYTE - 1));
  assign o_w_data = data_q;
  assign o_wr     = wr_q;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      word_q <= '0;
      bidx_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      wr_q <= o_fire;
      if (o_fire)
        data_q <= i_byte_req ? i_byte : word_q[NB_DATA-1 -: NB_BYTE];
      if (i_load) begin
        word_q <= i_word;
        bidx_q <= '0;
      end else if (o_fire && i_send) begin
        word_q <= word_q << NB_BYTE;
        bidx_q <= bidx_q + 1'b1;
      end
    end
endmodule

// File: rtl/dbg_dump_sequencer.sv
// dbg_dump_sequencer: streams a framed PC/register/memory snapshot to the UART TX FIFO.
// Frame: A5, PC, regs 0..N-1, mem 0..count-1 (MSB byte first), 5A.
module dbg_dump_sequencer
  import dbg_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_MEM_ADDR = 5,
  parameter int NB_BYTE     = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [NB_MEM_ADDR:0]   i_mem_count,
  input  logic [NB_DATA-1:0]     i_pc,
  input  logic [NB_DATA-1:0]     i_reg_data,
  input  logic [NB_DATA-1:0]     i_mem_data,
  input  logic                   i_tx_full,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  output logic [NB_BYTE-1:0]     o_w_data,
  output logic                   o_wr_uart,
  output logic                   o_busy,
  output logic                   o_done
);
  localparam int IW = (NB_REG_ADDR > NB_MEM_ADDR ? NB_REG_ADDR : NB_MEM_ADDR) + 1;
  localparam logic [IW-1:0] REG_LAST = IW'((1 << NB_REG_ADDR) - 1);
  localparam logic [NB_MEM_ADDR:0] MEM_MAX = (NB_MEM_ADDR + 1)'(1 << NB_MEM_ADDR);
  state_t                 state_q;
  sec_t                   sec_q;
  logic [IW-1:0]          idx_q;
  logic [NB_MEM_ADDR:0]   cnt_q;
  logic [NB_REG_ADDR-1:0] reg_addr_q;
  logic [NB_MEM_ADDR-1:0] mem_addr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   fire;
  logic                   last;
  logic [IW-1:0]          sec_last;
  logic [IW-1:0]          nidx;
  logic [NB_DATA-1:0]     word_d;
  assign sec_last = (sec_q == SEC_REG) ? REG_LAST : IW'(cnt_q) - IW'(1);
  assign nidx     = idx_q + IW'(1);
  assign word_d   = (sec_q == SEC_PC) ? i_pc : (sec_q == SEC_REG) ? i_reg_data : i_mem_data;
  dbg_word_serializer #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)) u_ser (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (state_q == S_LATCH),
    .i_word    (word_d),
    .i_send    (state_q == S_SEND),
    .i_byte_req(state_q == S_HDR || state_q == S_TRL),
    .i_byte    (state_q == S_HDR ? NB_BYTE'(DBG_HDR) : NB_BYTE'(DBG_TRL)),
    .i_tx_full (i_tx_full),
    .o_w_data  (o_w_data),
    .o_wr      (o_wr_uart),
    .o_fire    (fire),
    .o_last    (last)
  );
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state_q    <= S_IDLE;
      sec_q      <= SEC_PC;
      idx_q      <= '0;
      cnt_q      <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            cnt_q   <= (i_mem_count > MEM_MAX) ? MEM_MAX : i_mem_count;
            busy_q  <= 1'b1;
            state_q <= S_HDR;
          end
        end
        S_HDR:
          if (fire) begin
            sec_q   <= SEC_PC;
            idx_q   <= '0;
            state_q <= S_ADDR;
          end
        S_ADDR:  state_q <= S_LATCH;
        S_LATCH: state_q <= S_SEND;
        S_SEND:
          if (last) begin
            // Next word in this section, else step to the next section (empty MEM skips to trailer).
            if (sec_q != SEC_PC && idx_q != sec_last) begin
              idx_q      <= nidx;
              reg_addr_q <= nidx[NB_REG_ADDR-1:0];
              mem_addr_q <= nidx[NB_MEM_ADDR-1:0];
              state_q    <= S_ADDR;
            end else if (sec_q == SEC_PC || (sec_q == SEC_REG && cnt_q != '0)) begin
              sec_q      <= (sec_q == SEC_PC) ? SEC_REG : SEC_MEM;
              idx_q      <= '0;
              reg_addr_q <= '0;
              mem_addr_q <= '0;
              state_q    <= S_ADDR;
            end else
              state_q <= S_TRL;
          end
        S_TRL:
          if (fire) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
  assign o_reg_addr = reg_addr_q;
  assign o_mem_addr = mem_addr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
endmodule
